wvar_bank: RTL and testbench

//  Parametrised working-variable bank for the SHA-2 compression function. Holds a..h and the

---
 rtl/wvar_bank_pkg.sv | 38 +++
 rtl/wvar_bank_if.sv | 43 ++++
 rtl/wvar_add.sv | 14 +
 rtl/wvar_bank.sv | 142 ++++++++++++++
 tb/tb_wvar_bank.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/wvar_bank_pkg.sv
// Package: wvar_bank_pkg
// Shared definitions for the SHA-2 working-variable bank.
//  - Word-width / round-count presets for the SHA-256 and SHA-512 families
//  - Standard initial hash values for SHA-256, SHA-224 and SHA-512
//  - FSM state encoding used by wvar_bank
// Optional feature macro used by files importing this package: WVAR_PROTO_CHK_EN
package wvar_bank_pkg;

    localparam int SHA256_W      = 32;
    localparam int SHA256_ROUNDS = 64;
    localparam int SHA512_W      = 64;
    localparam int SHA512_ROUNDS = 80;

    // H0 occupies the most significant word in every constant below.
    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] SHA224_IV = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [511:0] SHA512_IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FOLD = 2'd2
    } state_t;

endpackage

// File: rtl/wvar_bank_if.sv
// Interface: wvar_bank_if
// Bundles the control/data signals between the round logic (master) and the
// working-variable bank (slave).
//  master -> slave : init, start, rnd_vld, new_a, new_e, iv
//  slave -> master : wv, rnd_idx, busy, digest, dig_vld, err (err only when
//                    WVAR_PROTO_CHK_EN is defined)
interface wvar_bank_if #(
    parameter int W     = 32,
    parameter int CNT_W = 6
);
    logic             init;
    logic             start;
    logic             rnd_vld;
    logic [W-1:0]     new_a;
    logic [W-1:0]     new_e;
    logic [8*W-1:0]   iv;
    logic [8*W-1:0]   wv;
    logic [CNT_W-1:0] rnd_idx;
    logic             busy;
    logic [8*W-1:0]   digest;
    logic             dig_vld;
`ifdef WVAR_PROTO_CHK_EN
    logic             err;

    modport master (
        output init, start, rnd_vld, new_a, new_e, iv,
        input  wv, rnd_idx, busy, digest, dig_vld, err
    );
    modport slave (
        input  init, start, rnd_vld, new_a, new_e, iv,
        output wv, rnd_idx, busy, digest, dig_vld, err
    );
`else
    modport master (
        output init, start, rnd_vld, new_a, new_e, iv,
        input  wv, rnd_idx, busy, digest, dig_vld
    );
    modport slave (
        input  init, start, rnd_vld, new_a, new_e, iv,
        output wv, rnd_idx, busy, digest, dig_vld
    );
`endif
endinterface

// File: rtl/wvar_add.sv
// Module: wvar_add
// W-bit modular adder used to fold the working variables into the chaining
// hash. The carry out is intentionally dropped (arithmetic mod 2^W).
//  a, b : W-bit operands
//  sum  : (a + b) mod 2^W
module wvar_add #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/wvar_bank.sv
// Module: wvar_bank
// Working-variable bank for the SHA-2 compression function. Holds a..h and
// the chaining hash H0..H7, shifts in one round result per rnd_vld and folds
// a..h into H once ROUNDS rounds have been consumed. H survives across blocks
// until the next accepted init, so multi-block messages chain naturally.
// Ports:
//  clk   : clock, rising edge
//  rst_n : asynchronous active-low reset
//  bus   : wvar_bank_if slave modport (init/start/rnd_vld/new_a/new_e/iv in;
//          wv/rnd_idx/busy/digest/dig_vld out, plus err with WVAR_PROTO_CHK_EN)
// Optional feature: WVAR_PROTO_CHK_EN adds a sticky protocol-violation flag.
module wvar_bank
    import wvar_bank_pkg::*;
#(
    parameter int W      = 32,
    parameter int ROUNDS = 64,
    parameter int CNT_W  = $clog2(ROUNDS)
) (
    input  logic       clk,
    input  logic       rst_n,
    wvar_bank_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

    state_t           state_reg, state_next;
    logic [W-1:0]     var_reg [8];    // index 0 = a ... 7 = h
    logic [W-1:0]     h_reg   [8];    // index 0 = H0 ... 7 = H7
    logic [W-1:0]     sum     [8];
    logic [W-1:0]     iv_w    [8];
    logic [CNT_W-1:0] idx_reg;
    logic             dig_vld_reg;

    logic acc_init, acc_start, do_shift, last_rnd, do_fold;

    // Word 0 always sits in the most significant slot of the packed buses.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_word
            assign iv_w[gi]                           = bus.iv[(8-gi)*W-1 -: W];
            assign bus.wv[(8-gi)*W-1 -: W]            = var_reg[gi];
            assign bus.digest[(8-gi)*W-1 -: W]        = h_reg[gi];
            wvar_add #(.W(W)) u_add (
                .a   (h_reg[gi]),
                .b   (var_reg[gi]),
                .sum (sum[gi])
            );
        end
    endgenerate

    assign bus.rnd_idx = idx_reg;
    assign bus.busy    = (state_reg != ST_IDLE);
    assign bus.dig_vld = dig_vld_reg;

    always_comb begin
        state_next = state_reg;
        acc_init   = 1'b0;
        acc_start  = 1'b0;
        do_shift   = 1'b0;
        last_rnd   = 1'b0;
        do_fold    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                acc_init  = bus.init;
                acc_start = bus.start;
                if (bus.start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.rnd_vld) begin
                    do_shift = 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        last_rnd   = 1'b1;
                        state_next = ST_FOLD;
                    end
                end
            end
            ST_FOLD: begin
                do_fold    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            dig_vld_reg <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                var_reg[i] <= '0;
                h_reg[i]   <= '0;
            end
        end else begin
            state_reg <= state_next;

            if (acc_init || acc_start) dig_vld_reg <= 1'b0;

            if (acc_init) begin
                for (int i = 0; i < 8; i++) h_reg[i] <= iv_w[i];
            end

            // With init and start together the block starts from iv directly,
            // since h_reg does not hold iv until the next edge.
            if (acc_start) begin
                idx_reg <= '0;
                for (int i = 0; i < 8; i++)
                    var_reg[i] <= acc_init ? iv_w[i] : h_reg[i];
            end

            if (do_shift) begin
                var_reg[0] <= bus.new_a;
                var_reg[4] <= bus.new_e;
                for (int i = 1; i < 4; i++) begin
                    var_reg[i]   <= var_reg[i-1];
                    var_reg[i+4] <= var_reg[i+3];
                end
                idx_reg <= last_rnd ? '0 : idx_reg + 1'b1;
            end

            if (do_fold) begin
                for (int i = 0; i < 8; i++) h_reg[i] <= sum[i];
                dig_vld_reg <= 1'b1;
            end
        end
    end

`ifdef WVAR_PROTO_CHK_EN
    logic err_reg;
    logic viol;

    assign viol    = ((state_reg != ST_IDLE) && (bus.init || bus.start)) ||
                     ((state_reg != ST_RUN) && bus.rnd_vld);
    assign bus.err = err_reg;

    // A violation in the same cycle as an accepted init still leaves err set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        err_reg <= 1'b0;
        else if (viol)     err_reg <= 1'b1;
        else if (acc_init) err_reg <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_wvar_bank.sv
// Testbench: tb_wvar_bank
// Directed checks of wvar_bank (W=32, ROUNDS=64): reset values, single block,
// modular wrap, chaining, stalls, ignored rnd_vld in IDLE, init-only load,
// mid-block reset and (with WVAR_PROTO_CHK_EN) the sticky error flag.
module tb_wvar_bank;
    import wvar_bank_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wvar_bank_if #(.W(32), .CNT_W(6)) bus ();

    wvar_bank #(.W(32), .ROUNDS(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [255:0] E1 = {32'h3F, 32'h3E, 32'h3D, 32'h3C,
                                   32'h13F, 32'h13E, 32'h13D, 32'h13C};
    localparam logic [255:0] E3 = {32'h7E, 32'h7C, 32'h7A, 32'h78,
                                   32'h27E, 32'h27C, 32'h27A, 32'h278};
    localparam logic [255:0] ALL_F = {8{32'hFFFFFFFF}};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One round, optionally preceded by idle gap cycles during which the
    // round index must hold at its expected value k.
    task automatic do_round(input int k, input logic [31:0] a, input logic [31:0] e,
                            input int gap);
        for (int g = 0; g < gap; g++) begin
            step();
            chk($sformatf("idx_hold_r%0d", k), 256'(bus.rnd_idx), 256'(k));
        end
        bus.rnd_vld = 1'b1;
        bus.new_a   = a;
        bus.new_e   = e;
        step();
        bus.rnd_vld = 1'b0;
        bus.new_a   = '0;
        bus.new_e   = '0;
    endtask

    task automatic begin_block(input logic do_init, input logic [255:0] iv_val);
        bus.iv    = iv_val;
        bus.init  = do_init;
        bus.start = 1'b1;
        step();
        bus.init  = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.init    = 1'b0;
        bus.start   = 1'b0;
        bus.rnd_vld = 1'b0;
        bus.new_a   = '0;
        bus.new_e   = '0;
        bus.iv      = '0;
        step();
        step();
        chk("rst_busy",    256'(bus.busy),    256'(0));
        chk("rst_wv",      bus.wv,            256'(0));
        chk("rst_digest",  bus.digest,        256'(0));
        chk("rst_dig_vld", 256'(bus.dig_vld), 256'(0));
        chk("rst_idx",     256'(bus.rnd_idx), 256'(0));
        rst_n = 1'b1;
        step();

        // Test 1: ordering
        begin_block(1'b1, 256'(0));
        chk("t1_busy", 256'(bus.busy),    256'(1));
        chk("t1_idx0", 256'(bus.rnd_idx), 256'(0));
        chk("t1_wv0",  bus.wv,            256'(0));
        for (int k = 0; k < 64; k++) begin
            do_round(k, 32'(k), 32'(32'h100 + k), 0);
            if (k == 0) chk("t1_idx1", 256'(bus.rnd_idx), 256'(1));
        end
        chk("t1_wv_end",   bus.wv,            E1);
        chk("t1_idx_wrap", 256'(bus.rnd_idx), 256'(0));
        chk("t1_fold_dv",  256'(bus.dig_vld), 256'(0));
        chk("t1_fold_bsy", 256'(bus.busy),    256'(1));
        step();
        chk("t1_dig_vld", 256'(bus.dig_vld), 256'(1));
        chk("t1_idle",    256'(bus.busy),    256'(0));
        chk("t1_digest",  bus.digest,        E1);

        // rnd_vld in IDLE is ignored
        do_round(0, 32'h1234, 32'h5678, 0);
        chk("idle_vld_wv",  bus.wv,         E1);
        chk("idle_vld_bsy", 256'(bus.busy), 256'(0));
        chk("idle_vld_dv",  256'(bus.dig_vld), 256'(1));
        step();

        // Test 3: chaining. a..h load from H; last four rounds re-inject the
        // H values so each word of the result doubles.
        begin_block(1'b0, 256'(0));
        chk("t3_load_wv", bus.wv,            E1);
        chk("t3_dv_clr",  256'(bus.dig_vld), 256'(0));
        for (int k = 0; k < 64; k++) begin
            do_round(k, (k >= 60) ? 32'(k) : 32'h0,
                        (k >= 60) ? 32'(32'h100 + k) : 32'h0, 0);
            if (k == 0)
                chk("t3_shift1", bus.wv, {32'h0, 32'h3F, 32'h3E, 32'h3D,
                                          32'h0, 32'h13F, 32'h13E, 32'h13D});
        end
        step();
        chk("t3_digest", bus.digest,        E3);
        chk("t3_dv",     256'(bus.dig_vld), 256'(1));

        // Test 2: modular wrap
        begin_block(1'b1, ALL_F);
        chk("t2_load_wv", bus.wv, ALL_F);
        for (int k = 0; k < 64; k++) do_round(k, 32'h1, 32'h1, 0);
        step();
        chk("t2_digest", bus.digest, 256'(0));
        chk("t2_dv",     256'(bus.dig_vld), 256'(1));

        // Test 4: stalls
        begin_block(1'b1, 256'(0));
        for (int k = 0; k < 64; k++)
            do_round(k, 32'(k), 32'(32'h100 + k), int'($urandom_range(0, 5)));
        step();
        chk("t4_digest", bus.digest,        E1);
        chk("t4_dv",     256'(bus.dig_vld), 256'(1));

        // init alone: H <= iv, dig_vld cleared, stays idle
        bus.iv   = SHA256_IV;
        bus.init = 1'b1;
        step();
        bus.init = 1'b0;
        chk("init_digest", bus.digest,        SHA256_IV);
        chk("init_dv",     256'(bus.dig_vld), 256'(0));
        chk("init_busy",   256'(bus.busy),    256'(0));

        // Test 5: reset mid-block
        begin_block(1'b0, 256'(0));
        for (int k = 0; k < 30; k++) do_round(k, 32'(k + 5), 32'(k + 9), 0);
        chk("t5_idx30", 256'(bus.rnd_idx), 256'(30));
        rst_n = 1'b0;
        step();
        chk("t5_busy",   256'(bus.busy),    256'(0));
        chk("t5_wv",     bus.wv,            256'(0));
        chk("t5_digest", bus.digest,        256'(0));
        chk("t5_dv",     256'(bus.dig_vld), 256'(0));
        chk("t5_idx",    256'(bus.rnd_idx), 256'(0));
        rst_n = 1'b1;
        step();

`ifdef WVAR_PROTO_CHK_EN
        // Test 6: sticky protocol error
        chk("t6_err_rst", 256'(bus.err), 256'(0));
        begin_block(1'b1, 256'(0));
        for (int k = 0; k < 64; k++) begin
            if (k == 10) begin
                bus.start = 1'b1;
                step();
                bus.start = 1'b0;
                chk("t6_err_set", 256'(bus.err),     256'(1));
                chk("t6_idx",     256'(bus.rnd_idx), 256'(10));
            end
            do_round(k, 32'(k), 32'(32'h100 + k), 0);
        end
        step();
        chk("t6_digest",  bus.digest,    E1);
        chk("t6_err_stk", 256'(bus.err), 256'(1));
        bus.init = 1'b1;
        step();
        bus.init = 1'b0;
        chk("t6_err_clr", 256'(bus.err), 256'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
